// File: rtl/cfu_mac_simd.sv
// cfu_mac_simd: LANES-wide signed dot-product MAC, sum(a_i * (b_i + offset)),
// with an internal accumulator and valid/ready handshakes on both sides.
// Three-stage pipeline: lane products, lane-sum tree, accumulator/op apply.
// The accumulator is touched only in the last stage, so ops never hazard.
module cfu_mac_simd #(
    parameter int LANES = 4,
    parameter int IN_W  = 8,
    parameter int OFF_W = 9,
    parameter int ACC_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [LANES*IN_W-1:0] in_a,
    input  logic [LANES*IN_W-1:0] in_b,
    input  logic [OFF_W-1:0]      in_offset,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_sum
);

    // b_i + offset never overflows at max(IN_W, OFF_W) + 1 bits
    localparam int BO_W  = ((IN_W > OFF_W) ? IN_W : OFF_W) + 1;
    localparam int PRD_W = IN_W + BO_W;
    localparam int SUM_W = PRD_W + $clog2(LANES);

    typedef enum logic [1:0] {
        OP_MAC      = 2'd0,
        OP_MAC_READ = 2'd1,
        OP_READ     = 2'd2,
        OP_CLEAR    = 2'd3
    } op_t;

    if (LANES < 1) begin : g_lanes_check
        $error("cfu_mac_simd: LANES must be at least 1");
    end

    logic                    enable;
    logic signed [IN_W-1:0]  a_l   [LANES];
    logic signed [IN_W-1:0]  b_l   [LANES];
    logic signed [BO_W-1:0]  bo_l  [LANES];
    logic signed [PRD_W-1:0] prod  [LANES];
    logic signed [PRD_W-1:0] s1_prod [LANES];
    logic                    s1_valid;
    op_t                     s1_op;
    logic signed [SUM_W-1:0] tree_sum;
    logic signed [SUM_W-1:0] s2_sum;
    logic                    s2_valid;
    op_t                     s2_op;
    logic [ACC_W-1:0]        sum_ext;
    logic [ACC_W-1:0]        acc_add;
    logic [ACC_W-1:0]        acc;

    // Whole pipeline stalls only while an unconsumed result is held
    always_comb begin
        enable   = !(out_valid && !out_ready);
        in_ready = enable && reset;
    end

    // Per-lane unpack, offset add and exact signed product
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            a_l[i]  = in_a[i*IN_W +: IN_W];
            b_l[i]  = in_b[i*IN_W +: IN_W];
            bo_l[i] = BO_W'(b_l[i]) + BO_W'($signed(in_offset));
            prod[i] = PRD_W'(a_l[i]) * PRD_W'(bo_l[i]);
        end
    end

    // S1: register lane products with the command's op and valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
        end else if (enable) begin
            s1_valid <= in_valid;
        end
        if (enable) begin
            s1_op   <= op_t'(in_op);
            s1_prod <= prod;
        end
    end

    // Lane-sum tree, widened so the sum of LANES products cannot overflow
    always_comb begin
        tree_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + SUM_W'(s1_prod[i]);
        end
    end

    // S2: register the lane sum with op and valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_valid <= 1'b0;
        end else if (enable) begin
            s2_valid <= s1_valid;
        end
        if (enable) begin
            s2_op  <= s1_op;
            s2_sum <= tree_sum;
        end
    end

    // Fit the lane sum to the accumulator width (sign-extend or truncate)
    if (SUM_W >= ACC_W) begin : g_trunc
        always_comb sum_ext = s2_sum[ACC_W-1:0];
    end else begin : g_sext
        always_comb sum_ext = {{(ACC_W-SUM_W){s2_sum[SUM_W-1]}}, s2_sum};
    end

    // Wrapping accumulate, no saturation
    always_comb acc_add = acc + sum_ext;

    // S3: apply op to the accumulator and produce results
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else if (enable) begin
            out_valid <= 1'b0;
            if (s2_valid) begin
                unique case (s2_op)
                    OP_MAC: begin
                        acc <= acc_add;
                    end
                    OP_MAC_READ: begin
                        acc       <= acc_add;
                        out_sum   <= acc_add;
                        out_valid <= 1'b1;
                    end
                    OP_READ: begin
                        out_sum   <= acc;
                        out_valid <= 1'b1;
                    end
                    OP_CLEAR: begin
                        acc <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cfu_mac_simd.sv
// tb_cfu_mac_simd: directed-vector bench for cfu_mac_simd with
// hand-computed expected results. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_cfu_mac_simd;

    localparam int LANES = 4;
    localparam int IN_W  = 8;
    localparam int OFF_W = 9;
    localparam int ACC_W = 32;

    localparam logic [1:0] OP_MAC      = 2'd0;
    localparam logic [1:0] OP_MAC_READ = 2'd1;
    localparam logic [1:0] OP_READ     = 2'd2;
    localparam logic [1:0] OP_CLEAR    = 2'd3;

    logic                  clk       = 1'b0;
    logic                  reset     = 1'b0;
    logic                  in_valid  = 1'b0;
    logic                  in_ready;
    logic [1:0]            in_op     = 2'd0;
    logic [LANES*IN_W-1:0] in_a      = '0;
    logic [LANES*IN_W-1:0] in_b      = '0;
    logic [OFF_W-1:0]      in_offset = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [ACC_W-1:0]      out_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cfu_mac_simd #(
        .LANES (LANES),
        .IN_W  (IN_W),
        .OFF_W (OFF_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_offset (in_offset),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [8:0] off, output int unsigned stalls);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_offset = off;
        stalls    = 0;
        #1;
        while (!in_ready && stalls < 50) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; optionally steps one cycle to consume
    task automatic wait_result(input logic step, output int unsigned lat, output logic [31:0] sum);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("result_timeout", 64'(out_valid), 64'd1);
        sum = out_sum;
        if (step) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned st;
        int unsigned st_sum;
        int unsigned lat;
        logic [31:0] sum;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        reset = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // MAC_READ {1,2,3,4}.{5,6,7,8} = 70, latency 3
        send(OP_MAC_READ, 32'h04030201, 32'h08070605, 9'd0, st);
        wait_result(1'b1, lat, sum);
        check("t1_latency", 64'(lat), 64'd2);
        check("t1_sum",     64'(sum), 64'd70);

        // 4 * (-128 * (-128 + 255)) = -65024
        send(OP_CLEAR, '0, '0, '0, st);
        send(OP_MAC,   32'h80808080, 32'h80808080, 9'h0FF, st);
        send(OP_READ,  '0, '0, '0, st);
        wait_result(1'b1, lat, sum);
        check("t2_latency", 64'(lat), 64'd2);
        check("t2_sum",     64'(sum), 64'hFFFF0200);

        // CLEAR, 3 x (+8), READ back-to-back
        st_sum = 0;
        send(OP_CLEAR, '0, '0, '0, st); st_sum += st;
        for (int i = 0; i < 3; i++) begin
            send(OP_MAC, 32'h01010101, 32'h01010101, 9'd1, st);
            st_sum += st;
        end
        send(OP_READ, '0, '0, '0, st); st_sum += st;
        check("t3_stalls", 64'(st_sum), 64'd0);
        wait_result(1'b1, lat, sum);
        check("t3_latency", 64'(lat), 64'd2);
        check("t3_sum",     64'(sum), 64'd24);

        // Backpressure: hold a READ result, then two MAC_READs (+8 each)
        out_ready = 1'b0;
        send(OP_READ, '0, '0, '0, st);
        wait_result(1'b0, lat, sum);
        check("t4_held_sum", 64'(sum), 64'd24);
        in_valid  = 1'b1;
        in_op     = OP_MAC_READ;
        in_a      = 32'h01010101;
        in_b      = 32'h01010101;
        in_offset = 9'd1;
        #1;
        check("t4_in_ready_low", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_frozen_valid", 64'(out_valid), 64'd1);
            check("t4_frozen_sum",   64'(out_sum),   64'd24);
        end
        out_ready = 1'b1;
        send(OP_MAC_READ, 32'h01010101, 32'h01010101, 9'd1, st);
        check("t4_release_stalls", 64'(st), 64'd0);
        send(OP_MAC_READ, 32'h01010101, 32'h01010101, 9'd1, st);
        wait_result(1'b1, lat, sum);
        check("t4_first_sum", 64'(sum), 64'd32);
        wait_result(1'b1, lat, sum);
        check("t4_second_lat", 64'(lat), 64'd0);
        check("t4_second_sum", 64'(sum), 64'd40);
        check("t4_no_dup", 64'(out_valid), 64'd0);

        // Wrap: preload 0x7FFFFFF0 = 10922*196608 + 2*65536 - 16, then +32
        st_sum = 0;
        send(OP_CLEAR, '0, '0, '0, st);
        for (int i = 0; i < 10922; i++) begin
            send(OP_MAC, 32'h80808080, 32'h80808080, 9'h100, st);
            st_sum += st;
        end
        for (int i = 0; i < 2; i++) begin
            send(OP_MAC, 32'h80808080, 32'h80808080, 9'd0, st);
            st_sum += st;
        end
        send(OP_MAC, 32'h000000F0, 32'h00000001, 9'd0, st); st_sum += st;
        check("t5_stalls", 64'(st_sum), 64'd0);
        send(OP_READ, '0, '0, '0, st);
        wait_result(1'b1, lat, sum);
        check("t5_preload", 64'(sum), 64'h7FFFFFF0);
        send(OP_MAC_READ, 32'h00000020, 32'h00000001, 9'd0, st);
        wait_result(1'b1, lat, sum);
        check("t5_wrap", 64'(sum), 64'h80000010);

        // Reset with a MAC_READ and a MAC in flight
        send(OP_MAC_READ, 32'h01010101, 32'h01010101, 9'd1, st);
        send(OP_MAC,      32'h01010101, 32'h01010101, 9'd1, st);
        reset = 1'b0;
        @(negedge clk);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_out_sum",   64'(out_sum),   64'd0);
        check("t6_in_ready",  64'(in_ready),  64'd0);
        reset = 1'b1;
        #1;
        check("t6_rel_ready", 64'(in_ready), 64'd1);
        repeat (4) @(negedge clk);
        check("t6_discarded", 64'(out_valid), 64'd0);
        send(OP_READ, '0, '0, '0, st);
        wait_result(1'b1, lat, sum);
        check("t6_latency", 64'(lat), 64'd2);
        check("t6_read",    64'(sum), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
